// File: rtl/clap_pkg.sv
// Constants and helpers shared by the clap energy front end and the clap detector.
package clap_pkg;

  localparam int ADC_SAMPLE_WIDTH = 12;
  localparam int ADC_MIDPOINT     = 2048;
  localparam int ENERGY_WIDTH     = 16;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clogb2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/sample_magnitude.sv
// Removes the ADC DC offset, takes the absolute value and registers it with
// its valid flag.
module sample_magnitude #(
  parameter int SAMPLE_WIDTH  = clap_pkg::ADC_SAMPLE_WIDTH,
  parameter int SAMPLE_OFFSET = clap_pkg::ADC_MIDPOINT
) (
  input  logic                    clock,
  input  logic                    counters_nreset,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  input  logic                    sample_valid,
  output logic [SAMPLE_WIDTH:0]   mag_data,
  output logic                    mag_valid
);

  localparam logic signed [SAMPLE_WIDTH:0] OFFSET = (SAMPLE_WIDTH+1)'(SAMPLE_OFFSET);

  logic signed [SAMPLE_WIDTH:0] centered;
  logic        [SAMPLE_WIDTH:0] mag;

  // One extra bit keeps the full-scale negative excursion (e.g. 0 -> 2048) exact.
  assign centered = $signed({1'b0, sample_data}) - OFFSET;
  assign mag      = centered[SAMPLE_WIDTH] ? $unsigned(-centered) : $unsigned(centered);

  always_ff @(posedge clock or negedge counters_nreset) begin
    if (!counters_nreset) begin
      mag_data  <= '0;
      mag_valid <= 1'b0;
    end else begin
      mag_valid <= sample_valid;
      if (sample_valid) mag_data <= mag;
    end
  end

endmodule

// File: rtl/clap_energy_window.sv
// Windowed mean-magnitude energy of the microphone stream, delivered to the
// clap detector over valid/ready with a saturating count of overwritten results.
module clap_energy_window #(
  parameter int SAMPLE_WIDTH  = clap_pkg::ADC_SAMPLE_WIDTH,
  parameter int SAMPLE_OFFSET = clap_pkg::ADC_MIDPOINT,
  parameter int WINDOW_LOG2   = 4,
  parameter int ENERGY_WIDTH  = clap_pkg::ENERGY_WIDTH,
  parameter int DROP_WIDTH    = 8
) (
  input  logic                    clock,
  input  logic                    counters_nreset,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic [ENERGY_WIDTH-1:0] energy_data,
  output logic                    energy_valid,
  input  logic                    energy_ready,
  output logic [DROP_WIDTH-1:0]   drop_count
);

  import clap_pkg::*;

  localparam int WINDOW    = 1 << WINDOW_LOG2;
  localparam int CNT_WIDTH = clogb2(WINDOW);
  localparam int ACC_WIDTH = SAMPLE_WIDTH + 1 + WINDOW_LOG2;
  localparam int WIDE      = (ACC_WIDTH > ENERGY_WIDTH) ? ACC_WIDTH : ENERGY_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] LAST      = CNT_WIDTH'(WINDOW - 1);
  localparam logic [WIDE-1:0]      SAT_LIMIT = WIDE'({ENERGY_WIDTH{1'b1}});

  logic [SAMPLE_WIDTH:0]   mag_data;
  logic                    mag_valid;
  logic [ACC_WIDTH-1:0]    acc;
  logic [ACC_WIDTH-1:0]    sum;
  logic [CNT_WIDTH-1:0]    count;
  logic [WIDE-1:0]         mean;
  logic [ENERGY_WIDTH-1:0] energy_next;
  logic                    window_done;

  assign sample_ready = 1'b1;

  sample_magnitude #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .SAMPLE_OFFSET(SAMPLE_OFFSET)
  ) u_sample_magnitude (
    .clock          (clock),
    .counters_nreset(counters_nreset),
    .sample_data    (sample_data),
    .sample_valid   (sample_valid),
    .mag_data       (mag_data),
    .mag_valid      (mag_valid)
  );

  assign sum         = acc + ACC_WIDTH'(mag_data);
  assign window_done = mag_valid && (count == LAST);
  assign mean        = WIDE'(sum >> WINDOW_LOG2);
  assign energy_next = (mean > SAT_LIMIT) ? '1 : mean[ENERGY_WIDTH-1:0];

  always_ff @(posedge clock or negedge counters_nreset) begin
    if (!counters_nreset) begin
      acc   <= '0;
      count <= '0;
    end else if (mag_valid) begin
      if (window_done) begin
        acc   <= '0;
        count <= '0;
      end else begin
        acc   <= sum;
        count <= count + CNT_WIDTH'(1);
      end
    end
  end

  // A fresh result always wins; it is only a drop if the held one was not taken.
  always_ff @(posedge clock or negedge counters_nreset) begin
    if (!counters_nreset) begin
      energy_data  <= '0;
      energy_valid <= 1'b0;
      drop_count   <= '0;
    end else if (window_done) begin
      energy_data  <= energy_next;
      energy_valid <= 1'b1;
      if (energy_valid && !energy_ready && (drop_count != '1))
        drop_count <= drop_count + DROP_WIDTH'(1);
    end else if (energy_valid && energy_ready) begin
      energy_valid <= 1'b0;
    end
  end

endmodule
